// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
// Optional signed-overflow output ovf enabled by `define SERIAL_SUB_SIGNED_OVF_EN.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  output logic             ovf,
`endif
  output logic             zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] diff_q;
  logic [CW-1:0]    cnt_q;
  logic             bw_q;
  logic             busy_q;
  logic             done_q;
  logic             bout_q;
  logic             zero_q;

  logic             bit_d;
  logic             bw_d;
  logic [WIDTH-1:0] diff_d;

  // Full-subtractor cell on the current LSBs of the operand shifters.
  assign bit_d  = a_q[0] ^ b_q[0] ^ bw_q;
  assign bw_d   = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & bw_q);
  assign diff_d = {bit_d, diff_q[WIDTH-1:1]};

`ifdef SERIAL_SUB_SIGNED_OVF_EN
  logic a_msb_q;
  logic b_msb_q;
  logic ovf_q;

  // Operand sign bits are kept aside because the shifters lose them.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (state_q != S_SHIFT && start) begin
      a_msb_q <= a[WIDTH-1];
      b_msb_q <= b[WIDTH-1];
    end else if (state_q == S_SHIFT && cnt_q == LAST) begin
      ovf_q <= (a_msb_q != b_msb_q) && (bit_d != a_msb_q);
    end
  end

  assign ovf = ovf_q;
`endif

  // Control FSM and datapath: accept, shift WIDTH bits, then pulse done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      bw_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bout_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= S_SHIFT;
            a_q     <= a;
            b_q     <= b;
            bw_q    <= bin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_SHIFT: begin
          diff_q <= diff_d;
          bw_q   <= bw_d;
          a_q    <= a_q >> 1;
          b_q    <= b_q >> 1;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            bout_q  <= bw_d;
            zero_q  <= (diff_d == '0);
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
  assign zero = zero_q;

endmodule
